uart_rx: RTL
============

# uart_rx

Serial receiver for the board's UART link: 8 data bits, LSB first, one start bit, one stop bit, no parity. It oversamples the asynchronous RX pin at i_Clock and samples each bit at its centre. Each received byte is delivered as a one-cycle valid pulse. It is the receive-side counterpart of the existing 115200-baud transmitter and sits between the RX pad and the command parser.

## Interface
- CLKS_PER_BIT, 139, i_Clock cycles per bit (16 MHz / 115200); legal range 8..511
- i_Clock  in  1  system clock, all logic on rising edge
- i_Rst_L  in  1  asynchronous, active-low reset
- i_Rx_Serial  in  1  raw RX pin, asynchronous to i_Clock, idles high
- o_Rx_DV  out  1  one-cycle pulse: o_Rx_Byte holds a newly received good byte
- o_Rx_Byte  out  8  last good byte; bit 0 is the first data bit received
- o_Rx_Frame_Err  out  1  one-cycle pulse: stop bit sampled low, byte discarded
- o_Rx_Active  out  1  high while a frame is being received

## Operation
- Input synchronizer: two flops, both reset to 1. All decisions use the second flop (rx_s).
- Counters:
  - r_Clock_Count: 9 bits, compared against CLKS_PER_BIT-1.
  - HALF = (CLKS_PER_BIT-1)/2, integer division; 69 at the default.
  - r_Bit_Index: 3 bits.
- s_IDLE:
  - Clears the count and index.
  - If r_Wait_High=1: r_Wait_High clears when rx_s=1; no start is detected while it is set.
  - Otherwise, rx_s=0 moves to s_RX_START_BIT with count 0 and sets o_Rx_Active.
- s_RX_START_BIT: count up to HALF. At count==HALF:
  - rx_s=0: count←0, go to s_RX_DATA_BITS.
  - rx_s=1: glitch. Go to s_IDLE, clear o_Rx_Active, raise no pulse.
- s_RX_DATA_BITS:
  - At count==CLKS_PER_BIT-1: r_Rx_Data[index]←rx_s, count←0.
  - index<7: index+1. index==7: index←0, go to s_RX_STOP_BIT.
- s_RX_STOP_BIT: at count==CLKS_PER_BIT-1:
  - rx_s=1: o_Rx_Byte←r_Rx_Data, o_Rx_DV←1.
  - rx_s=0: o_Rx_Frame_Err←1, r_Wait_High←1, o_Rx_Byte unchanged.
  - Either case: go to s_CLEANUP and clear o_Rx_Active.
- s_CLEANUP: one cycle. Clears o_Rx_DV and o_Rx_Frame_Err, goes to s_IDLE.
- Undefined state encodings go to s_IDLE.

## Timing
- Reset values: o_Rx_DV=0, o_Rx_Frame_Err=0, o_Rx_Active=0, o_Rx_Byte=8'h00.
  - Internal: state s_IDLE, counters 0, r_Wait_High=0, synchronizer flops 1.
- Reset asserted mid-frame: immediate return to reset values; any partial byte is lost. After release, a line still low is treated as a fresh start edge.
- Latency: take edge 0 as the first rising edge at which i_Rx_Serial is low.
  - State enters s_RX_START_BIT at edge 2.
  - Centre-of-start sample at edge 3+HALF.
  - o_Rx_DV (or o_Rx_Frame_Err) is set at edge 3+HALF+9·CLKS_PER_BIT, which is 1323 at the default.
- o_Rx_DV and o_Rx_Frame_Err are high for exactly one cycle and never together.
- o_Rx_Active rises at edge 2 and falls on the same edge that sets DV or Err.
- A start edge is accepted on the first s_IDLE cycle after s_CLEANUP. Back-to-back frames with a single stop bit must be received without loss.
- Low pulse shorter than HALF+1 cycles: no output pulse, back to s_IDLE.
- Break (line held low): one frame error, then no further activity until the line returns high.
- Baud tolerance: the receiver must still decode correctly with a ±2% baud mismatch between transmitter and receiver.

## Structure
- Shared package uart_pkg holds:
  - State encodings s_IDLE..s_CLEANUP (3-bit), common with the transmitter.
  - Default CLKS_PER_BIT=139.
  - Counter width constant (9).
- One sub-module: uart_rx_sync, a 2-flop synchronizer with an async active-low reset value of 1.

## Test plan
- Send 8'hA5 at nominal baud → exactly one o_Rx_DV pulse at edge 1323, o_Rx_Byte=8'hA5, o_Rx_Frame_Err never high.
- Send 8'h00, 8'hFF and 8'h55 back-to-back with one stop bit each → three DV pulses spaced 10·139 cycles apart, with the correct bytes in order.
- 40-cycle low glitch on an idle line → no DV, no Err, o_Rx_Active high then low before edge 73; a following 8'h3C is received correctly.
- Send 8'h81 with the stop bit forced low and the line then held low 5000 cycles → one Err pulse, o_Rx_Byte keeps its previous value, no further pulses until the line goes high; a subsequent 8'h81 gives DV.
- Assert i_Rst_L low during data bit 4 → all outputs at reset values immediately; the next full frame 8'h7E is received correctly.
- Transmit 8'hC3 at +2% and −2% baud → correct byte each time, no Err.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default bit period
// and counter width used by both link directions.
package uart_pkg;

    typedef enum logic [2:0] {
        s_IDLE         = 3'b000,
        s_RX_START_BIT = 3'b001,
        s_RX_DATA_BITS = 3'b010,
        s_RX_STOP_BIT  = 3'b011,
        s_CLEANUP      = 3'b100
    } uart_state_e;

    localparam int CLKS_PER_BIT_DEF = 139;
    localparam int CNT_W            = 9;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side output bundle: byte strobe, error strobe, busy flag.
interface uart_rx_if;

    logic       o_Rx_DV;
    logic [7:0] o_Rx_Byte;
    logic       o_Rx_Frame_Err;
    logic       o_Rx_Active;

    modport master (
        output o_Rx_DV,
        output o_Rx_Byte,
        output o_Rx_Frame_Err,
        output o_Rx_Active
    );

    modport slave (
        input o_Rx_DV,
        input o_Rx_Byte,
        input o_Rx_Frame_Err,
        input o_Rx_Active
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the RX pad; resets to the idle (high) level.
module uart_rx_sync (
    input  logic i_Clock,
    input  logic i_Rst_L,
    input  logic i_async,
    output logic o_sync
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= i_async;
            sync_q <= meta_q;
        end
    end

    assign o_sync = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled, centre-sampled bits, one-cycle
// byte-valid and frame-error strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic      i_Clock,
    input  logic      i_Rst_L,
    input  logic      i_Rx_Serial,
    uart_rx_if.master rx_if
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

    logic rx_s;

    uart_rx_sync u_sync (
        .i_Clock (i_Clock),
        .i_Rst_L (i_Rst_L),
        .i_async (i_Rx_Serial),
        .o_sync  (rx_s)
    );

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] clock_count_q, clock_count_d;
    logic [2:0]       bit_index_q, bit_index_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             wait_high_q, wait_high_d;
    logic             rx_dv_q, rx_dv_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             frame_err_q, frame_err_d;
    logic             active_q, active_d;

    always_comb begin
        state_d       = state_q;
        clock_count_d = clock_count_q;
        bit_index_d   = bit_index_q;
        rx_data_d     = rx_data_q;
        wait_high_d   = wait_high_q;
        rx_dv_d       = rx_dv_q;
        rx_byte_d     = rx_byte_q;
        frame_err_d   = frame_err_q;
        active_d      = active_q;

        case (state_q)
            s_IDLE: begin
                clock_count_d = '0;
                bit_index_d   = '0;
                // After a break, ignore the line until it returns high
                if (wait_high_q) begin
                    if (rx_s) wait_high_d = 1'b0;
                end else if (!rx_s) begin
                    state_d  = s_RX_START_BIT;
                    active_d = 1'b1;
                end
            end
            s_RX_START_BIT: begin
                if (clock_count_q == HALF) begin
                    clock_count_d = '0;
                    if (!rx_s) begin
                        state_d = s_RX_DATA_BITS;
                    end else begin
                        state_d  = s_IDLE;
                        active_d = 1'b0;
                    end
                end else begin
                    clock_count_d = clock_count_q + 1'b1;
                end
            end
            s_RX_DATA_BITS: begin
                if (clock_count_q == LAST) begin
                    clock_count_d          = '0;
                    rx_data_d[bit_index_q] = rx_s;
                    if (bit_index_q == 3'd7) begin
                        bit_index_d = '0;
                        state_d     = s_RX_STOP_BIT;
                    end else begin
                        bit_index_d = bit_index_q + 1'b1;
                    end
                end else begin
                    clock_count_d = clock_count_q + 1'b1;
                end
            end
            s_RX_STOP_BIT: begin
                if (clock_count_q == LAST) begin
                    clock_count_d = '0;
                    state_d       = s_CLEANUP;
                    active_d      = 1'b0;
                    if (rx_s) begin
                        rx_byte_d = rx_data_q;
                        rx_dv_d   = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        wait_high_d = 1'b1;
                    end
                end else begin
                    clock_count_d = clock_count_q + 1'b1;
                end
            end
            s_CLEANUP: begin
                rx_dv_d     = 1'b0;
                frame_err_d = 1'b0;
                state_d     = s_IDLE;
            end
            default: begin
                state_d = s_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q       <= s_IDLE;
            clock_count_q <= '0;
            bit_index_q   <= '0;
            rx_data_q     <= '0;
            wait_high_q   <= 1'b0;
            rx_dv_q       <= 1'b0;
            rx_byte_q     <= '0;
            frame_err_q   <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            clock_count_q <= clock_count_d;
            bit_index_q   <= bit_index_d;
            rx_data_q     <= rx_data_d;
            wait_high_q   <= wait_high_d;
            rx_dv_q       <= rx_dv_d;
            rx_byte_q     <= rx_byte_d;
            frame_err_q   <= frame_err_d;
            active_q      <= active_d;
        end
    end

    assign rx_if.o_Rx_DV        = rx_dv_q;
    assign rx_if.o_Rx_Byte      = rx_byte_q;
    assign rx_if.o_Rx_Frame_Err = frame_err_q;
    assign rx_if.o_Rx_Active    = active_q;

endmodule
